// File: rtl/bus_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : bus_arbiter_if
// Brief    : RQ/GRANT handshake bundle between the cores and one bus arbiter.
//            Arb_Error is present only when ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = 2
);
  logic [N_MASTERS-1:0] Bus_RQ;
  logic                 Bus_Mem_Ready;
  logic [N_MASTERS-1:0] Bus_GRANT;
  logic                 Bus_Busy;
  logic [ID_W-1:0]      Grant_Owner;
`ifdef ARB_TIMEOUT_EN
  logic                 Arb_Error;
`endif

  // Arbiter side (responder end of the handshake)
  modport slave (
    input  Bus_RQ,
    input  Bus_Mem_Ready,
    output Bus_GRANT,
    output Bus_Busy,
`ifdef ARB_TIMEOUT_EN
    output Arb_Error,
`endif
    output Grant_Owner
  );

  modport master (
    output Bus_RQ,
    output Bus_Mem_Ready,
    input  Bus_GRANT,
    input  Bus_Busy,
`ifdef ARB_TIMEOUT_EN
    input  Arb_Error,
`endif
    input  Grant_Owner
  );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : bus_arbiter
// Brief    : Round-robin arbiter for one shared memory bus; waits for memory
//            Ready to drop before re-granting. Optional ARB_TIMEOUT_EN macro
//            adds a grant-length watchdog and the sticky Arb_Error flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  bus_arbiter_if.slave     bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANTED = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  if ((ID_W != $clog2(N_MASTERS)) || (TIMEOUT_CYCLES < 1)) begin : g_paramCheck
    $error("bus_arbiter: inconsistent ID_W / N_MASTERS or TIMEOUT_CYCLES < 1");
  end

  logic [1:0]           r_state;
  logic [1:0]           w_nextState;
  logic [N_MASTERS-1:0] r_grant;
  logic [N_MASTERS-1:0] w_grantNext;
  logic [ID_W-1:0]      r_owner;
  logic [ID_W-1:0]      w_ownerNext;
  logic [ID_W-1:0]      r_rrPtr;
  logic [ID_W-1:0]      w_rrPtrNext;
  logic                 r_busy;
  logic [ID_W-1:0]      w_cand;
  logic [ID_W-1:0]      w_sel;
  logic                 w_selValid;
  logic                 w_ownerReq;
  logic                 w_timeout;

  assign w_ownerReq = bus.Bus_RQ[r_owner];

  // First requester searching upward from the slot after the last owner
  always_comb begin
    w_cand     = '0;
    w_sel      = '0;
    w_selValid = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      w_cand = ID_W'((int'(r_rrPtr) + k) % N_MASTERS);
      if (!w_selValid && bus.Bus_RQ[w_cand]) begin
        w_selValid = 1'b1;
        w_sel      = w_cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [C_CNT_W-1:0] r_count;
  logic               r_error;

  // The compare sees the count before this edge's increment
  assign w_timeout = (r_count == C_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_GRANTED) r_count <= r_count + 1'b1;
      else                      r_count <= '0;
      if ((r_state == S_GRANTED) && w_ownerReq && w_timeout) r_error <= 1'b1;
    end
  end

  assign bus.Arb_Error = r_error;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_rrPtr <= ID_W'(N_MASTERS - 1);
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_grant <= w_grantNext;
      r_owner <= w_ownerNext;
      r_rrPtr <= w_rrPtrNext;
      r_busy  <= (w_nextState != S_IDLE);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (w_selValid)                w_nextState = S_GRANTED;
      S_GRANTED: if (!w_ownerReq || w_timeout)  w_nextState = S_RELEASE;
      S_RELEASE: if (!bus.Bus_Mem_Ready)        w_nextState = S_IDLE;
      default:                                  w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_grantNext = r_grant;
    w_ownerNext = r_owner;
    w_rrPtrNext = r_rrPtr;
    case (r_state)
      S_IDLE: begin
        if (w_selValid) begin
          w_grantNext        = '0;
          w_grantNext[w_sel] = 1'b1;
          w_ownerNext        = w_sel;
          w_rrPtrNext        = w_sel;
        end
      end
      S_GRANTED: begin
        if (w_nextState == S_RELEASE) w_grantNext = '0;
      end
      default: w_grantNext = '0;
    endcase
  end

  assign bus.Bus_GRANT   = r_grant;
  assign bus.Bus_Busy    = r_busy;
  assign bus.Grant_Owner = r_owner;

  a_grantOneHot: assert property (@(posedge clk) disable iff (reset) $onehot0(r_grant));

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_arbiter
// Brief    : Self-checking bench for bus_arbiter (table, directed and random).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;

  bus_arbiter_if #(.N_MASTERS(N), .ID_W(2)) busIf ();

  bus_arbiter #(.N_MASTERS(N), .ID_W(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       rdy;
    logic [3:0] expGrant;
    logic [1:0] expOwner;
    logic       expBusy;
  } vec_t;

  vec_t tbl[32];

  // Behavioural reference: who owns the bus, whether we are in turnaround
  int         mOwner;
  bit         mRel;
  int         mLast;
  int         mOwnerOut;
  int         mCnt;
  bit         mErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic modelStep(input bit rst, input logic [3:0] rq, input logic rdy);
    bit found;
    int c;
    if (rst) begin
      mOwner = -1; mRel = 0; mLast = N - 1; mOwnerOut = 0; mCnt = 0; mErr = 0;
    end else if (mOwner >= 0) begin
      if (!rq[mOwner]) begin
        mOwner = -1; mRel = 1;
      end
`ifdef ARB_TIMEOUT_EN
      else begin
        mCnt++;
        if (mCnt == TO) begin
          mOwner = -1; mRel = 1; mErr = 1;
        end
      end
`endif
    end else if (mRel) begin
      if (!rdy) mRel = 0;
    end else begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (mLast + k) % N;
        if (!found && rq[c]) begin
          found = 1; mOwner = c; mOwnerOut = c; mLast = c; mCnt = 0;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   expOrder[5];
    int   gap;
    int   n;
    logic [3:0] rq;
    logic [3:0] expG;
    nCompared   = 0;
    nMismatched = 0;
    reset = 1'b1;
    busIf.Bus_RQ = '0;
    busIf.Bus_Mem_Ready = 1'b0;

    // ---------------- table-driven vectors ----------------
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[15] = '{1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[16] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[17] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[18] = '{1'b0, 4'b0111, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[19] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 2'd2, 1'b1};
    tbl[20] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 2'd2, 1'b0};
    tbl[21] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[22] = '{1'b0, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b1};
    for (int i = 23; i <= 27; i++) tbl[i] = '{1'b0, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b1};
    tbl[28] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[29] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
    tbl[30] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b1};
    tbl[31] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0};

    for (int i = 0; i < 32; i++) begin
      reset               = tbl[i].rst;
      busIf.Bus_RQ        = tbl[i].rq;
      busIf.Bus_Mem_Ready = tbl[i].rdy;
      cycle();
      check($sformatf("tbl%0d_grant", i), 32'(busIf.Bus_GRANT),   32'(tbl[i].expGrant));
      check($sformatf("tbl%0d_owner", i), 32'(busIf.Grant_Owner), 32'(tbl[i].expOwner));
      check($sformatf("tbl%0d_busy",  i), 32'(busIf.Bus_Busy),    32'(tbl[i].expBusy));
    end

    // ---------------- round-robin with all cores requesting ----------------
    expOrder = '{0, 1, 2, 3, 0};
    reset = 1'b1; busIf.Bus_RQ = '0; busIf.Bus_Mem_Ready = 1'b0;
    cycle();
    reset = 1'b0;
    busIf.Bus_RQ = 4'b1111;
    gap = 0;
    for (int g = 0; g < 5; g++) begin
      cycle();
      while (busIf.Bus_GRANT == 4'b0000 && gap < 20) begin
        gap++;
        cycle();
      end
      expG = 4'b0001 << expOrder[g];
      check($sformatf("rr%0d_grant", g), 32'(busIf.Bus_GRANT),   32'(expG));
      check($sformatf("rr%0d_owner", g), 32'(busIf.Grant_Owner), 32'(expOrder[g]));
      if (g > 0) check($sformatf("rr%0d_gap", g), 32'(gap), 32'd2);
      cycle();
      cycle();
      check($sformatf("rr%0d_hold", g), 32'(busIf.Bus_GRANT), 32'(expG));
      busIf.Bus_RQ = 4'b1111 & ~expG;
      cycle();
      check($sformatf("rr%0d_drop", g), 32'(busIf.Bus_GRANT), 32'd0);
      gap = 1;
      busIf.Bus_RQ = 4'b1111;
    end

`ifdef ARB_TIMEOUT_EN
    // ---------------- grant watchdog ----------------
    reset = 1'b1; busIf.Bus_RQ = '0; busIf.Bus_Mem_Ready = 1'b0;
    cycle();
    reset = 1'b0;
    check("to_err_reset", 32'(busIf.Arb_Error), 32'd0);
    busIf.Bus_RQ = 4'b1000;
    cycle();
    check("to_grant", 32'(busIf.Bus_GRANT), 32'b1000);
    n = 1;
    cycle();
    while (busIf.Bus_GRANT == 4'b1000 && n < 30) begin
      n++;
      cycle();
    end
    check("to_length", 32'(n), 32'(TO));
    check("to_err_set", 32'(busIf.Arb_Error), 32'd1);
    busIf.Bus_RQ = 4'b1001;
    cycle();
    cycle();
    check("to_next_grant", 32'(busIf.Bus_GRANT), 32'b0001);
    busIf.Bus_RQ = 4'b0000;
    cycle();
    cycle();
    check("to_err_sticky", 32'(busIf.Arb_Error), 32'd1);
`endif

    // ---------------- randomized against the reference model ----------------
    reset = 1'b1; busIf.Bus_RQ = '0; busIf.Bus_Mem_Ready = 1'b0;
    cycle();
    modelStep(1'b1, 4'b0000, 1'b0);
    reset = 1'b0;
    rq = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      reset               = ($urandom_range(0, 499) == 0);
      busIf.Bus_RQ        = rq;
      busIf.Bus_Mem_Ready = ($urandom_range(0, 3) == 0);
      cycle();
      modelStep(reset, busIf.Bus_RQ, busIf.Bus_Mem_Ready);
      expG = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
      check("rnd_grant", 32'(busIf.Bus_GRANT),   32'(expG));
      check("rnd_owner", 32'(busIf.Grant_Owner), 32'(mOwnerOut));
      check("rnd_busy",  32'(busIf.Bus_Busy),    32'((mOwner >= 0) || mRel));
`ifdef ARB_TIMEOUT_EN
      check("rnd_error", 32'(busIf.Arb_Error),   32'(mErr));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

`default_nettype wire
